mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Arbitrates the single-ported RAM between the instruction-fetch path (the PC
//   register's iaddr) and the data path (load/store). Sequences each access with
//   a grant FSM, holds the grant until RAM completes, and returns iwait/dwait.
//   Data has priority, with one-shot fairness so fetch is never starved.
// PARAMETERS
//   TIMEOUT   16  grant cycles without ACCESS before abort (>=2)
// PORTS
//   CLK       in   1   clock, rising edge
//   nRST      in   1   asynchronous active-low reset
//   iREN      in   1   instruction read request
//   iaddr     in   32  instruction address (from PC)
//   iwait     out  1   0 = iload valid this cycle; else fetch stalls
//   iload     out  32  fetched instruction
//   dREN      in   1   data read request
//   dWEN      in   1   data write request
//   daddr     in   32  data address
//   dstore    in   32  data write value
//   dwait     out  1   0 = data access completes this cycle
//   dload     out  32  data read value
//   ramREN    out  1   RAM read enable
//   ramWEN    out  1   RAM write enable
//   ramaddr   out  32  RAM address
//   ramstore  out  32  RAM write data
//   ramload   in   32  RAM read data
//   ramstate  in   2   00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
//   bus_err   out  1   sticky error flag (ERROR or timeout seen)
// BEHAVIOUR
//   Reset: state IDLE, last_d=0, tcnt=0, bus_err=0; ramREN=ramWEN=0,
//     ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
//   States IDLE, DGRANT, IGRANT (registered). RAM outputs decoded from state only.
//   IDLE: dreq=dREN|dWEN. dreq && !(last_d && iREN) -> DGRANT; else iREN -> IGRANT;
//     else stay. No RAM enable in IDLE.
//   DGRANT: ramaddr=daddr, ramstore=dstore; dWEN -> ramWEN=1,ramREN=0 (write wins
//     if both); else ramREN=1. ramstate==ACCESS -> dwait=0, dload=ramload that
//     cycle, last_d<=1, next IDLE.
//   IGRANT: ramaddr=iaddr, ramREN=1. ACCESS -> iwait=0, iload=ramload, last_d<=0,
//     next IDLE.
//   Waits are combinational; exactly one of iwait/dwait may be 0 in a cycle.
//   Min latency: request seen in IDLE cycle N, RAM driven N+1; ACCESS in N+1
//     completes in N+1 (2-cycle access). BUSY/FREE extend grant.
//   Request dropped while granted (dreq=0 in DGRANT / iREN=0 in IGRANT): enables
//     drop same cycle, no completion, next IDLE, last_d unchanged.
//   ramstate ERROR in a grant: no completion (wait stays 1), bus_err<=1, next IDLE;
//     requester retries.
//   tcnt: cleared on grant entry, +1 each grant cycle without ACCESS; reaching
//     TIMEOUT-1 -> abort as ERROR. tcnt saturates, never wraps.
//   bus_err clears only on reset. nRST mid-grant: enables drop immediately.
//   iload/dload are combinational passes of ramload, 0 when not completing.
// TESTING
//   iREN=1 only, iaddr=0x40, ramstate ACCESS at grant -> ramaddr=0x40 one cycle
//     after request, iwait=0 for 1 cycle, iload=ramload.
//   dREN=1 & iREN=1 same cycle, RAM 1 BUSY then ACCESS -> DGRANT first (dwait=0
//     cycle 3), then IGRANT; data access never immediately repeated while iREN=1.
//   dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0,
//     ramstore=0xDEADBEEF.
//   ramstate stuck BUSY, TIMEOUT=16 -> abort after 16 grant cycles, bus_err=1,
//     dwait stays 1, FSM re-grants next request.
//   ramstate ERROR mid-fetch, then nRST low mid-grant -> bus_err=1 then 0; all
//     outputs at reset values asynchronously.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported RAM between instruction fetch and the load/store
// data path: data has priority, and a one-shot fairness bit keeps fetch from starving.
module mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2
    } state_t;

    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [1:0] RS_ERROR  = 2'b11;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t          state_r;
    logic            last_d_r;
    logic [TW-1:0]   tcnt_r;
    logic            bus_err_r;

    logic            dreq_s;
    logic            dgo_s;
    logic            igo_s;
    logic            live_s;
    logic            acc_s;
    logic            done_s;
    logic            abort_s;

    // Grant qualification: a grant only drives the RAM while its requester still asks.
    always_comb begin
        dreq_s  = dREN | dWEN;
        dgo_s   = (state_r == DGRANT) && dreq_s;
        igo_s   = (state_r == IGRANT) && iREN;
        live_s  = dgo_s | igo_s;
        acc_s   = (ramstate == RS_ACCESS);
        done_s  = live_s && acc_s;
        abort_s = live_s && !acc_s && ((ramstate == RS_ERROR) || (tcnt_r == TLAST));
    end

    // RAM-side drive and requester handshakes; a write wins over a read in the data grant.
    always_comb begin
        ramREN   = igo_s | (dgo_s & ~dWEN);
        ramWEN   = dgo_s & dWEN;
        if (dgo_s) begin
            ramaddr  = daddr;
            ramstore = dstore;
        end else if (igo_s) begin
            ramaddr  = iaddr;
            ramstore = 32'h0000_0000;
        end else begin
            ramaddr  = 32'h0000_0000;
            ramstore = 32'h0000_0000;
        end
        dwait = ~(dgo_s & acc_s);
        iwait = ~(igo_s & acc_s);
        dload = (dgo_s & acc_s) ? ramload : 32'h0000_0000;
        iload = (igo_s & acc_s) ? ramload : 32'h0000_0000;
        bus_err = bus_err_r;
    end

    // Grant FSM with fairness bit, grant-age counter and sticky error flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            last_d_r  <= 1'b0;
            tcnt_r    <= {TW{1'b0}};
            bus_err_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    tcnt_r <= {TW{1'b0}};
                    if (dreq_s && !(last_d_r && iREN)) begin
                        state_r <= DGRANT;
                    end else if (iREN) begin
                        state_r <= IGRANT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DGRANT, IGRANT: begin
                    if (!live_s) begin
                        state_r <= IDLE;
                    end else if (done_s) begin
                        state_r  <= IDLE;
                        last_d_r <= (state_r == DGRANT);
                    end else if (abort_s) begin
                        state_r   <= IDLE;
                        bus_err_r <= 1'b1;
                    end else if (tcnt_r != TLAST) begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end else begin
                        tcnt_r <= tcnt_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of owner, grant age and fairness.
module tb_mem_arbiter;
    localparam int TIMEOUT = 16;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, bus_err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int total = 0;
    int bad   = 0;

    // model: owner 0 none, 1 data, 2 fetch; age = grant cycles already spent
    int m_owner;
    int m_age;
    bit m_last_d;
    bit m_err;
    logic        exp_iwait, exp_dwait, exp_ren, exp_wen;
    logic [31:0] exp_addr, exp_store, exp_iload, exp_dload;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .bus_err(bus_err)
    );

    task automatic model_reset();
        m_owner = 0; m_age = 0; m_last_d = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_outputs();
        bit dact, iact, acc;
        dact = (m_owner == 1) && (dREN || dWEN);
        iact = (m_owner == 2) && iREN;
        acc  = (ramstate == 2'b10);
        exp_wen   = dact && dWEN;
        exp_ren   = iact || (dact && !dWEN);
        exp_addr  = dact ? daddr : (iact ? iaddr : 32'h0);
        exp_store = dact ? dstore : 32'h0;
        exp_dwait = !(dact && acc);
        exp_iwait = !(iact && acc);
        exp_dload = (dact && acc) ? ramload : 32'h0;
        exp_iload = (iact && acc) ? ramload : 32'h0;
    endtask

    // advance one clock, updating the model from the inputs present at the edge
    task automatic tick();
        int  n_owner, n_age;
        bit  n_last, n_err, active, acc, fail;
        n_owner = m_owner; n_age = m_age; n_last = m_last_d; n_err = m_err;
        acc = (ramstate == 2'b10);
        if (m_owner == 0) begin
            n_age = 0;
            if ((dREN || dWEN) && !(m_last_d && iREN)) n_owner = 1;
            else if (iREN) n_owner = 2;
        end else begin
            active = (m_owner == 1) ? (dREN || dWEN) : iREN;
            fail   = (ramstate == 2'b11) || (m_age + 1 == TIMEOUT);
            if (!active) n_owner = 0;
            else if (acc) begin n_last = (m_owner == 1); n_owner = 0; end
            else if (fail) begin n_owner = 0; n_err = 1'b1; end
            else n_age = m_age + 1;
        end
        @(posedge CLK);
        m_owner = n_owner; m_age = n_age; m_last_d = n_last; m_err = n_err;
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;
        ramload = 32'h0; ramstate = 2'b00;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({ramREN, ramWEN, iwait, dwait, bus_err} !== 5'b00110) begin
            bad++; $display("FAIL reset_ctrl: got %b want 00110", {ramREN, ramWEN, iwait, dwait, bus_err});
        end
        total++;
        if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
            bad++; $display("FAIL reset_data: got %h want 0", {ramaddr, ramstore, iload, dload});
        end
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        logic [31:0] word;
        word = $urandom;
        iREN = 1'b1; iaddr = 32'h40; ramstate = 2'b10; ramload = word;
        #1;
        total++;
        if ({ramREN, iwait} !== 2'b01) begin
            bad++; $display("FAIL fetch_idle: got %b want 01", {ramREN, iwait});
        end
        tick();
        #1;
        total++;
        if ({ramREN, ramWEN, iwait, dwait, ramaddr} !== {4'b1001, 32'h40}) begin
            bad++; $display("FAIL fetch_grant: got %b/%h want 1001/00000040", {ramREN, ramWEN, iwait, dwait}, ramaddr);
        end
        total++;
        if (iload !== word) begin
            bad++; $display("FAIL fetch_iload: got %h want %h", iload, word);
        end
        tick();
        iREN = 1'b0; ramstate = 2'b00;
        #1;
        total++;
        if ({ramREN, iwait, iload} !== {2'b01, 32'h0}) begin
            bad++; $display("FAIL fetch_after: got %b/%h want 01/0", {ramREN, iwait}, iload);
        end
        tick();
    endtask

    task automatic test_priority();
        logic [31:0] word;
        word = $urandom;
        dREN = 1'b1; iREN = 1'b1; daddr = 32'h200; iaddr = 32'h44; ramstate = 2'b01;
        tick();
        #1;
        total++;
        if ({ramREN, dwait, iwait, ramaddr} !== {3'b111, 32'h200}) begin
            bad++; $display("FAIL prio_busy: got %b/%h want 111/00000200", {ramREN, dwait, iwait}, ramaddr);
        end
        tick();
        ramstate = 2'b10; ramload = word;
        #1;
        total++;
        if ({dwait, iwait, dload} !== {2'b01, word}) begin
            bad++; $display("FAIL prio_dcomplete: got %b/%h want 01/%h", {dwait, iwait}, dload, word);
        end
        tick();
        ramstate = 2'b00;
        #1;
        total++;
        if (ramREN !== 1'b0) begin
            bad++; $display("FAIL prio_idle: got ramREN=%b want 0", ramREN);
        end
        tick();
        ramstate = 2'b10;
        #1;
        total++;
        if ({ramREN, dwait, iwait, ramaddr} !== {3'b110, 32'h44}) begin
            bad++; $display("FAIL prio_fair: got %b/%h want 110/00000044", {ramREN, dwait, iwait}, ramaddr);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_write();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        tick();
        ramstate = 2'b10;
        #1;
        total++;
        if ({ramWEN, ramREN, dwait, ramaddr, ramstore} !== {3'b100, 32'h100, 32'hDEADBEEF}) begin
            bad++; $display("FAIL write: got %b/%h/%h want 100/00000100/deadbeef", {ramWEN, ramREN, dwait}, ramaddr, ramstore);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        dREN = 1'b1; daddr = 32'h300; ramstate = 2'b01;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            #1;
            if (ramREN !== 1'b1 || dwait !== 1'b1) early++;
            tick();
        end
        total++;
        if (early != 0) begin
            bad++; $display("FAIL timeout_hold: got %0d bad grant cycles want 0", early);
        end
        #1;
        total++;
        if ({ramREN, dwait, bus_err} !== 3'b011) begin
            bad++; $display("FAIL timeout_abort: got %b want 011", {ramREN, dwait, bus_err});
        end
        tick();
        ramstate = 2'b10;
        #1;
        total++;
        if ({ramREN, dwait, bus_err} !== 3'b101) begin
            bad++; $display("FAIL timeout_regrant: got %b want 101", {ramREN, dwait, bus_err});
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_error_reset();
        nRST = 1'b0;
        #1;
        model_reset();
        total++;
        if (bus_err !== 1'b0) begin
            bad++; $display("FAIL err_clear: got %b want 0", bus_err);
        end
        nRST = 1'b1;
        iREN = 1'b1; iaddr = 32'h80; ramstate = 2'b01;
        tick();
        tick();
        ramstate = 2'b11;
        #1;
        total++;
        if ({ramREN, iwait, iload} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL err_nocomplete: got %b/%h want 11/0", {ramREN, iwait}, iload);
        end
        tick();
        ramstate = 2'b01;
        #1;
        total++;
        if ({ramREN, bus_err} !== 2'b01) begin
            bad++; $display("FAIL err_sticky: got %b want 01", {ramREN, bus_err});
        end
        tick();
        #1;
        total++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h80}) begin
            bad++; $display("FAIL err_retry: got %b/%h want 1/00000080", ramREN, ramaddr);
        end
        nRST = 1'b0;
        #1;
        model_reset();
        total++;
        if ({ramREN, ramWEN, iwait, dwait, bus_err, ramaddr} !== {5'b00110, 32'h0}) begin
            bad++; $display("FAIL err_async_reset: got %b/%h want 00110/0", {ramREN, ramWEN, iwait, dwait, bus_err}, ramaddr);
        end
        idle_inputs();
        nRST = 1'b1;
        tick();
    endtask

    task automatic test_random();
        int errs, r;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            iREN = ($urandom_range(0, 3) != 0);
            dREN = ($urandom_range(0, 2) == 0);
            dWEN = ($urandom_range(0, 3) == 0);
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = $urandom_range(0, 19);
            ramstate = (r < 8) ? 2'b10 : (r < 14) ? 2'b01 : (r < 19) ? 2'b00 : 2'b11;
            #1;
            model_outputs();
            total++;
            if ({ramREN, ramWEN, iwait, dwait, bus_err, ramaddr, ramstore, iload, dload} !==
                {exp_ren, exp_wen, exp_iwait, exp_dwait, m_err, exp_addr, exp_store, exp_iload, exp_dload}) begin
                bad++; errs++;
                if (errs <= 5)
                    $display("FAIL random cyc %0d: got %b %h %h %h %h want %b %h %h %h %h", c,
                             {ramREN, ramWEN, iwait, dwait, bus_err}, ramaddr, ramstore, iload, dload,
                             {exp_ren, exp_wen, exp_iwait, exp_dwait, m_err}, exp_addr, exp_store, exp_iload, exp_dload);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_timeout();
        test_error_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
